// File: rtl/arrhythmia_pkg.sv
// rtl/arrhythmia_pkg.sv - shared defaults, loader state encoding and count-width helper
package arrhythmia_pkg;

    localparam int DEF_BITSIZE        = 16;
    localparam int DEF_WINDOW         = 10;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
    localparam int CNT_W              = $clog2(DEF_WINDOW + 1);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_HOLD   = 2'd3
    } loader_state_e;

    function automatic int cnt_width(input int window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/ecg_window_loader_if.sv
// rtl/ecg_window_loader_if.sv - sample stream, core launch/result and status bundle of the window loader
interface ecg_window_loader_if
    import arrhythmia_pkg::*;
#(
    parameter int BITSIZE = DEF_BITSIZE,
    parameter int WINDOW  = DEF_WINDOW
);
    localparam int CW = cnt_width(WINDOW);

    logic [BITSIZE-1:0]        sample_in;
    logic                      sample_valid;
    logic                      sample_ready;
    logic [BITSIZE*WINDOW-1:0] x_out;
    logic                      core_start;
    logic                      done_flag_in;
    logic [BITSIZE*2-1:0]      y_in;
    logic [BITSIZE*2-1:0]      result;
    logic                      result_valid;
    logic                      result_ready;
    logic                      busy;
    logic [CW-1:0]             window_count;
    logic                      timeout_err;
    logic                      err_clr;

    modport master (
        output sample_in, sample_valid, done_flag_in, y_in, result_ready, err_clr,
        input  sample_ready, x_out, core_start, result, result_valid, busy,
               window_count, timeout_err
    );

    modport slave (
        input  sample_in, sample_valid, done_flag_in, y_in, result_ready, err_clr,
        output sample_ready, x_out, core_start, result, result_valid, busy,
               window_count, timeout_err
    );

endinterface

// File: rtl/ecg_window_loader.sv
// rtl/ecg_window_loader.sv - serial-to-window sample loader that launches the classifier and captures its result
module ecg_window_loader
    import arrhythmia_pkg::*;
#(
    parameter int BITSIZE        = DEF_BITSIZE,
    parameter int WINDOW         = DEF_WINDOW,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    ecg_window_loader_if.slave  bus
);
    localparam int CW = cnt_width(WINDOW);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    loader_state_e                     state_q, state_d;
    logic [CW-1:0]                     window_count_q, window_count_d;
    logic [WINDOW-2:0][BITSIZE-1:0]    stage_q, stage_d;
    logic [BITSIZE*WINDOW-1:0]         x_out_q, x_out_d;
    logic [TW-1:0]                     timer_q, timer_d;
    logic [BITSIZE*2-1:0]              result_q, result_d;
    logic                              result_valid_q, result_valid_d;
    logic                              timeout_err_q, timeout_err_d;

    logic sample_ready;
    logic accept;
    logic last_accept;
    logic timer_expired;

    assign accept        = bus.sample_valid && sample_ready;
    assign last_accept   = accept && (state_q == S_FILL) && (window_count_q == CW'(WINDOW - 1));
    assign timer_expired = (timer_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_FILL;
            window_count_q <= '0;
            stage_q        <= '0;
            x_out_q        <= '0;
            timer_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            window_count_q <= window_count_d;
            stage_q        <= stage_d;
            x_out_q        <= x_out_d;
            timer_q        <= timer_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL:   if (last_accept) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                // done beats a coincident timeout
                if (bus.done_flag_in)    state_d = S_HOLD;
                else if (timer_expired)  state_d = S_FILL;
            end
            S_HOLD:   if (result_valid_q && bus.result_ready) state_d = S_FILL;
            default:  state_d = S_FILL;
        endcase
    end

    // HOLD may prefetch all but the final sample so x_out never changes under a pending result
    always_comb begin
        sample_ready = 1'b0;
        case (state_q)
            S_FILL:  sample_ready = 1'b1;
            S_HOLD:  sample_ready = (window_count_q < CW'(WINDOW - 1));
            default: sample_ready = 1'b0;
        endcase
    end

    always_comb begin
        window_count_d = window_count_q;
        stage_d        = stage_q;
        x_out_d        = x_out_q;
        timer_d        = timer_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        timeout_err_d  = timeout_err_q;

        if (last_accept) begin
            for (int k = 0; k < WINDOW - 1; k++) begin
                x_out_d[(WINDOW-1-k)*BITSIZE +: BITSIZE] = stage_q[k];
            end
            x_out_d[BITSIZE-1:0] = bus.sample_in;
            window_count_d       = '0;
        end else if (accept) begin
            for (int k = 0; k < WINDOW - 1; k++) begin
                if (window_count_q == CW'(k)) stage_d[k] = bus.sample_in;
            end
            window_count_d = window_count_q + CW'(1);
        end

        if (bus.err_clr) timeout_err_d = 1'b0;

        case (state_q)
            S_LAUNCH: timer_d = '0;
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (bus.done_flag_in) begin
                    result_d       = bus.y_in;
                    result_valid_d = 1'b1;
                end else if (timer_expired) begin
                    timeout_err_d = 1'b1;
                end
            end
            S_HOLD:   if (result_valid_q && bus.result_ready) result_valid_d = 1'b0;
            default:  ;
        endcase
    end

    assign bus.sample_ready = sample_ready;
    assign bus.core_start   = (state_q == S_LAUNCH);
    assign bus.busy         = (state_q == S_LAUNCH) || (state_q == S_WAIT);
    assign bus.x_out        = x_out_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.window_count = window_count_q;
    assign bus.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_ecg_window_loader.sv
// tb/tb_ecg_window_loader.sv - scoreboard bench for the ECG window loader
module tb_ecg_window_loader;
    localparam int B  = 16;
    localparam int W  = 10;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ecg_window_loader_if #(.BITSIZE(B), .WINDOW(W)) bus ();

    ecg_window_loader #(.BITSIZE(B), .WINDOW(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [B*W-1:0] x_q[$];
    logic [2*B-1:0] r_q[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (bus.core_start) begin
                if (x_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_core_start: got x_out %0h expected no launch", bus.x_out);
                end else begin
                    check("x_out_at_launch", 256'(bus.x_out), 256'(x_q.pop_front()));
                end
            end
            if (bus.result_valid && bus.result_ready) begin
                if (r_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_result: got %0h expected none", bus.result);
                end else begin
                    check("result_consumed", 256'(bus.result), 256'(r_q.pop_front()));
                end
            end
        end
    end

    task automatic send_sample(input logic [B-1:0] d);
        int n;
        bus.sample_in    = d;
        bus.sample_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.sample_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!bus.sample_ready) begin
            vectors++; miscompares++;
            $display("FAIL sample_ready_timeout: got 0 expected 1 for sample %0h", d);
        end
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
    endtask

    task automatic pulse_ready();
        @(posedge clk); #1 bus.result_ready = 1'b1;
        @(posedge clk); #1 bus.result_ready = 1'b0;
    endtask

    initial begin
        logic [B*W-1:0] x2;
        logic [B*W-1:0] x3;
        logic [B*W-1:0] x5;
        int acc;

        bus.sample_in = '0; bus.sample_valid = 1'b0; bus.done_flag_in = 1'b0;
        bus.y_in = '0; bus.result_ready = 1'b0; bus.err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        @(negedge clk);
        check("rst_sample_ready", 256'(bus.sample_ready), 256'(1));
        check("rst_window_count", 256'(bus.window_count), 256'(0));
        check("rst_x_out", 256'(bus.x_out), 256'(0));
        check("rst_result_valid", 256'(bus.result_valid), 256'(0));
        check("rst_busy", 256'(bus.busy), 256'(0));
        check("rst_timeout_err", 256'(bus.timeout_err), 256'(0));
        @(posedge clk); #1;

        // round 1: 0x0100..0x0A00, done five cycles after launch
        x_q.push_back(160'h0100_0200_0300_0400_0500_0600_0700_0800_0900_0A00);
        for (int i = 1; i <= W; i++) send_sample(16'(i * 256));
        @(negedge clk);
        check("launch_core_start", 256'(bus.core_start), 256'(1));
        check("launch_busy", 256'(bus.busy), 256'(1));
        check("launch_sample_ready", 256'(bus.sample_ready), 256'(0));
        check("launch_window_count", 256'(bus.window_count), 256'(0));
        @(negedge clk);
        check("wait_core_start_low", 256'(bus.core_start), 256'(0));
        check("wait_busy", 256'(bus.busy), 256'(1));
        repeat (4) @(posedge clk);
        #1 bus.done_flag_in = 1'b1; bus.y_in = 32'h0020_0F10;
        r_q.push_back(32'h0020_0F10);
        @(posedge clk); #1 bus.done_flag_in = 1'b0;
        @(negedge clk);
        check("hold_result_valid", 256'(bus.result_valid), 256'(1));
        check("hold_busy", 256'(bus.busy), 256'(0));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("hold_result_stable", 256'(bus.result), 256'(32'h0020_0F10));
        end
        pulse_ready();
        @(negedge clk);
        check("consumed_result_valid", 256'(bus.result_valid), 256'(0));
        check("consumed_sample_ready", 256'(bus.sample_ready), 256'(1));
        @(posedge clk); #1;

        // round 2: fast done, then prefetch during HOLD
        x2 = '0;
        for (int i = 0; i < W; i++) x2 = (x2 << B) | (B*W)'(16'h1000 + i);
        x_q.push_back(x2);
        for (int i = 0; i < W; i++) send_sample(16'h1000 + 16'(i));
        @(posedge clk); #1 bus.done_flag_in = 1'b1; bus.y_in = 32'hCAFE_0001;
        r_q.push_back(32'hCAFE_0001);
        @(posedge clk); #1 bus.done_flag_in = 1'b0;

        x3 = '0;
        for (int i = 0; i < W; i++) x3 = (x3 << B) | (B*W)'(16'h2001 + i);
        x_q.push_back(x3);
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            bus.sample_in = 16'h2001 + 16'(acc);
            bus.sample_valid = 1'b1;
            @(negedge clk);
            if (bus.sample_ready) acc++;
            @(posedge clk); #1;
        end
        check("prefetch_accepted", 256'(acc), 256'(9));
        check("prefetch_window_count", 256'(bus.window_count), 256'(9));
        check("prefetch_x_out_held", 256'(bus.x_out), 256'(x2));
        check("prefetch_ready_low", 256'(bus.sample_ready), 256'(0));

        // round 3: done held high across LAUNCH, captured in first WAIT cycle
        bus.done_flag_in = 1'b1; bus.y_in = 32'h1234_5678;
        r_q.push_back(32'h1234_5678);
        pulse_ready();
        send_sample(16'h200A);
        @(negedge clk);
        check("done_ignored_in_launch", 256'(bus.result_valid), 256'(0));
        @(negedge clk);
        check("first_wait_not_yet_valid", 256'(bus.result_valid), 256'(0));
        @(negedge clk);
        check("captured_after_first_wait", 256'(bus.result_valid), 256'(1));
        check("captured_result", 256'(bus.result), 256'(32'h1234_5678));
        bus.done_flag_in = 1'b0;
        pulse_ready();

        // round 4: timeout
        for (int i = 0; i < W; i++) send_sample(16'h3000 + 16'(i));
        x_q.push_back(160'h3000_3001_3002_3003_3004_3005_3006_3007_3008_3009);
        for (int i = 0; i < TO + 1; i++) begin
            @(negedge clk);
            check("timeout_busy_window", 256'({bus.busy, bus.timeout_err}), 256'(2'b10));
        end
        @(negedge clk);
        check("timeout_err_set", 256'(bus.timeout_err), 256'(1));
        check("timeout_result_valid", 256'(bus.result_valid), 256'(0));
        check("timeout_sample_ready", 256'(bus.sample_ready), 256'(1));
        check("timeout_result_kept", 256'(bus.result), 256'(32'h1234_5678));
        @(posedge clk); #1 bus.err_clr = 1'b1;
        @(posedge clk); #1 bus.err_clr = 1'b0;
        @(negedge clk);
        check("err_clr", 256'(bus.timeout_err), 256'(0));
        @(posedge clk); #1;

        // round 5: reset mid-WAIT aborts with no capture
        x5 = '0;
        for (int i = 0; i < W; i++) x5 = (x5 << B) | (B*W)'(16'h4000 + i);
        x_q.push_back(x5);
        for (int i = 0; i < W; i++) send_sample(16'h4000 + 16'(i));
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("midwait_rst_x_out", 256'(bus.x_out), 256'(0));
        check("midwait_rst_result", 256'(bus.result), 256'(0));
        check("midwait_rst_flags", 256'({bus.result_valid, bus.timeout_err, bus.busy, bus.core_start}), 256'(0));
        check("midwait_rst_count", 256'(bus.window_count), 256'(0));
        check("midwait_rst_ready", 256'(bus.sample_ready), 256'(1));
        bus.done_flag_in = 1'b1; bus.y_in = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        check("midwait_no_capture", 256'(bus.result_valid), 256'(0));
        bus.done_flag_in = 1'b0;

        check("x_queue_drained", 256'(x_q.size()), 256'(0));
        check("r_queue_drained", 256'(r_q.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ecg_window_loader.md
Name: ecg_window_loader

Overview:
Upstream front-end of top_arrhythmia. Accepts ECG samples serially over a valid/ready handshake and assembles them into one WINDOW-sample parallel vector. Launches the classifier core with a one-cycle start pulse and waits for its done flag. Captures the 2-word classifier output into a result register with its own valid/ready handshake, and flags a sticky error if the core never completes.

Parameters:
BITSIZE, 16, width of one sample and of one output word (two's complement fixed-point, passed through unmodified)
WINDOW, 10, samples per classification window; must be >= 2
TIMEOUT_CYCLES, 1024, maximum cycles to wait for done_flag_in after launch; must be >= 2

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
sample_in  input  BITSIZE  incoming ECG sample
sample_valid  input  1  sample_in is valid
sample_ready  output  1  loader accepts a sample this cycle
x_out  output  BITSIZE*WINDOW  window vector to core; first-accepted sample in the MSB slot
core_start  output  1  one-cycle launch pulse to core
done_flag_in  input  1  core completion flag
y_in  input  BITSIZE*2  core result
result  output  BITSIZE*2  captured classification
result_valid  output  1  result holds an unconsumed classification
result_ready  input  1  downstream consumes result
busy  output  1  high in LAUNCH and WAIT
window_count  output  clog2(WINDOW+1)  samples currently buffered
timeout_err  output  1  sticky core-timeout flag
err_clr  input  1  clears timeout_err

Behaviour:
- Reset: one clock; reset is synchronous and active-low. While reset==0 at a clk edge, all registers clear: state=FILL, window_count=0, staging buffer=0, x_out=0, core_start=0, result=0, result_valid=0, timeout_err=0, timer=0. Reset asserted in any state, including mid-WAIT, aborts the operation with no result and no error.
- Accept condition: sample_valid && sample_ready at a clk edge. Sample k (0-based within the window) is written to staging slot k.
- FILL: sample_ready=1.
  - Accept with window_count < WINDOW-1: window_count+1.
  - Accept with window_count == WINDOW-1: x_out <= staging slots 0..WINDOW-2 plus the new sample (slot 0 in the MSBs); window_count <= 0; next state LAUNCH.
  - x_out changes only on this transition and holds stable until the next one.
- LAUNCH: core_start=1 for exactly this cycle; sample_ready=0; timer <= 0; done_flag_in ignored (stale done from the previous window). Next state WAIT.
- WAIT: sample_ready=0; timer increments every cycle.
  - done_flag_in==1: result <= y_in; result_valid <= 1; next state HOLD.
  - Otherwise, timer == TIMEOUT_CYCLES-1: timeout_err <= 1; result unchanged; next state FILL.
  - done wins if both occur in the same cycle.
- HOLD: result_valid=1.
  - sample_ready = (window_count < WINDOW-1): prefetch of the next window is allowed, but the final sample is only accepted in FILL.
  - result_valid && result_ready: result_valid <= 0; next state FILL; buffered samples retained.
- result_valid is registered; result is stable while result_valid=1.
- sample_ready is combinational from state and window_count only, never from sample_valid.
- timeout_err: set as above; cleared by err_clr==1, or by reset; a set in the same cycle as err_clr wins. timeout_err does not block operation.
- busy = state is LAUNCH or WAIT.
- Latency: core_start is asserted in the cycle after the WINDOW-th accept. result_valid rises in the cycle after done_flag_in is sampled high in WAIT.

Decomposition:
- Shared package arrhythmia_pkg: BITSIZE, WINDOW, TIMEOUT_CYCLES defaults; loader state enum (FILL, LAUNCH, WAIT, HOLD); a count-width constant.
- No sub-module; FSM, staging buffer, timer and result register live in a single module.

Test Plan:
- Feed 0x0100..0x0A00 back-to-back after reset release -> x_out = {0100,0200,...,0A00} in the cycle after the 10th accept; core_start high exactly 1 cycle; busy high; sample_ready low.
- Drive done_flag_in=1 with y_in=0x00200F10 five cycles after core_start -> result=0x00200F10 and result_valid=1 one cycle later. Hold result_ready=0 for 8 cycles -> result stable. Pulse result_ready -> result_valid=0 and state returns to FILL.
- During HOLD, present 12 samples -> only 9 accepted (window_count=9). After result consumed, the 10th is accepted and a new launch occurs; x_out unchanged until then.
- TIMEOUT_CYCLES=16, done never asserted -> timeout_err=1 after 16 WAIT cycles, result_valid stays 0, sample_ready=1. err_clr=1 -> timeout_err=0.
- Hold done_flag_in=1 continuously through LAUNCH -> ignored in LAUNCH; captured in the first WAIT cycle.
- Drive reset=0 for one edge mid-WAIT -> all outputs zero, state FILL, window_count=0. A later done_flag_in causes no capture.
